// File: rtl/add_accum_unit.sv
// -----------------------------------------------------------------------------
// add_accum_unit
//   Adds, subtracts or accumulates two unsigned WIDTH-bit operands and produces
//   a registered ACC_WIDTH-bit result. Both sides use valid/ready handshakes.
//   A result is held until downstream takes it, so output backpressure
//   never loses data.
//
//   Modes (in_mode): 00 ADD, 01 ACC, 10 SUB, 11 LOAD
//
// Parameters
//   WIDTH      operand width
//   ACC_WIDTH  accumulator/result width (must be >= WIDTH+1)
//   CNT_WIDTH  width of the ACC-operation counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat (= !out_valid | out_ready)
//   in_a/in_b  unsigned operands
//   in_mode    operation select
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_data   result
//   out_carry  carry / borrow / overflow flag of this beat
//   out_count  ACC operations since the last LOAD (saturating)
//
// Configuration macro
//   ADD_ACCUM_SATURATE_EN  when defined, ACC overflow clamps to all-ones and
//                          SUB underflow clamps to zero; out_carry still flags
//                          the event. Undefined: modular wrap.
// -----------------------------------------------------------------------------
module add_accum_unit #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_carry,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [ACC_WIDTH-1:0] acc;
    logic                 accept;

    // Operands widened by one extra bit above ACC_WIDTH so every sum/diff
    // keeps its carry or borrow in the top bit.
    logic [ACC_WIDTH:0] a_ext;
    logic [ACC_WIDTH:0] b_ext;
    logic [ACC_WIDTH:0] pair_sum;
    logic [ACC_WIDTH:0] acc_sum;
    logic [ACC_WIDTH:0] diff;

    logic [ACC_WIDTH-1:0] nxt_data;
    logic                 nxt_carry;
    logic [ACC_WIDTH-1:0] nxt_acc;
    logic [CNT_WIDTH-1:0] nxt_count;

    // Ready depends only on the output register state, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign a_ext    = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_a};
    assign b_ext    = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_b};
    // a+b always fits in ACC_WIDTH bits because ACC_WIDTH >= WIDTH+1.
    assign pair_sum = a_ext + b_ext;
    assign acc_sum  = {1'b0, acc} + pair_sum;
    assign diff     = a_ext - b_ext;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_data  = pair_sum[ACC_WIDTH-1:0];
        nxt_carry = 1'b0;
        nxt_acc   = acc;
        nxt_count = out_count;
        case (mode_e'(in_mode))
            MODE_ADD: begin
                nxt_data = pair_sum[ACC_WIDTH-1:0];
            end
            MODE_ACC: begin
                nxt_carry = acc_sum[ACC_WIDTH];
`ifdef ADD_ACCUM_SATURATE_EN
                nxt_data  = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                               : acc_sum[ACC_WIDTH-1:0];
`else
                nxt_data  = acc_sum[ACC_WIDTH-1:0];
`endif
                nxt_acc   = nxt_data;
                nxt_count = (out_count == CNT_MAX) ? CNT_MAX
                                                   : out_count + 1'b1;
            end
            MODE_SUB: begin
                nxt_carry = (in_a < in_b);
`ifdef ADD_ACCUM_SATURATE_EN
                nxt_data  = (in_a < in_b) ? '0 : diff[ACC_WIDTH-1:0];
`else
                nxt_data  = diff[ACC_WIDTH-1:0];
`endif
            end
            MODE_LOAD: begin
                nxt_data  = pair_sum[ACC_WIDTH-1:0];
                nxt_acc   = pair_sum[ACC_WIDTH-1:0];
                nxt_count = CNT_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                // A new beat replaces any result being drained this cycle.
                acc       <= nxt_acc;
                out_data  <= nxt_data;
                out_carry <= nxt_carry;
                out_count <= nxt_count;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_accum_unit.sv
// -----------------------------------------------------------------------------
// tb_add_accum_unit
//   Self-checking bench for add_accum_unit. A vector table feeds a scoreboard
//   (expected beats queued on accept, compared when the DUT delivers them),
//   followed by hand-written sequences for counter saturation, a narrow
//   accumulator overflow, output backpressure and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_add_accum_unit;

`ifdef ADD_ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] M_ADD  = 2'b00;
    localparam logic [1:0] M_ACC  = 2'b01;
    localparam logic [1:0] M_SUB  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        logic        carry;
        logic [7:0]  count;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_carry;
    logic [7:0]  out_count;

    logic        n_in_valid = 1'b0;
    logic        n_in_ready;
    logic [7:0]  n_in_a = '0;
    logic [7:0]  n_in_b = '0;
    logic [1:0]  n_in_mode = '0;
    logic        n_out_valid;
    logic        n_out_ready = 1'b1;
    logic [8:0]  n_out_data;
    logic        n_out_carry;
    logic [7:0]  n_out_count;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   sb_en     = 1'b0;
    vec_t sb_q[$];
    vec_t mon_e;
    vec_t vecs[12];

    always #5 clk = ~clk;

    add_accum_unit #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_count(out_count)
    );

    add_accum_unit #(.WIDTH(8), .ACC_WIDTH(9), .CNT_WIDTH(8)) dut_narrow (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_a(n_in_a), .in_b(n_in_b), .in_mode(n_in_mode),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .out_carry(n_out_carry), .out_count(n_out_count)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive one beat on the wide DUT; queue its expectation on the accept edge.
    task automatic send(input vec_t v);
        int waited = 0;
        bit ok = 1'b1;
        in_valid = 1'b1;
        in_mode  = v.mode;
        in_a     = v.a;
        in_b     = v.b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 20) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) sb_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a beat presented with out_ready high is consumed at the next edge.
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_data",  32'(out_data),  32'(mon_e.data));
                check("sb_carry", 32'(out_carry), 32'(mon_e.carry));
                check("sb_count", 32'(out_count), 32'(mon_e.count));
            end
        end
    end

    task automatic narrow_step(input logic [1:0] mode, input logic [7:0] a,
                               input logic [7:0] b, input logic [8:0] exp_data,
                               input logic exp_carry, input logic [7:0] exp_count,
                               input string tag);
        n_in_valid = 1'b1;
        n_in_mode  = mode;
        n_in_a     = a;
        n_in_b     = b;
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        check({tag, "_valid"}, 32'(n_out_valid), 32'd1);
        check({tag, "_data"},  32'(n_out_data),  32'(exp_data));
        check({tag, "_carry"}, 32'(n_out_carry), 32'(exp_carry));
        check({tag, "_count"}, 32'(n_out_count), 32'(exp_count));
    endtask

    initial begin
        vecs[0]  = '{M_ADD,  8'd200, 8'd100, 16'h012C, 1'b0, 8'd0};
        vecs[1]  = '{M_LOAD, 8'd255, 8'd255, 16'd510,  1'b0, 8'd1};
        vecs[2]  = '{M_ACC,  8'd1,   8'd0,   16'd511,  1'b0, 8'd2};
        vecs[3]  = '{M_ACC,  8'd1,   8'd0,   16'd512,  1'b0, 8'd3};
        vecs[4]  = '{M_SUB,  8'd5,   8'd7,   SAT ? 16'h0000 : 16'hFFFE, 1'b1, 8'd3};
        vecs[5]  = '{M_SUB,  8'd7,   8'd5,   16'd2,    1'b0, 8'd3};
        vecs[6]  = '{M_ADD,  8'd255, 8'd255, 16'd510,  1'b0, 8'd3};
        vecs[7]  = '{M_ACC,  8'd0,   8'd0,   16'd512,  1'b0, 8'd4};
        vecs[8]  = '{M_SUB,  8'd0,   8'd0,   16'd0,    1'b0, 8'd4};
        vecs[9]  = '{M_LOAD, 8'd0,   8'd0,   16'd0,    1'b0, 8'd1};
        vecs[10] = '{M_ACC,  8'd255, 8'd255, 16'd510,  1'b0, 8'd2};
        vecs[11] = '{M_SUB,  8'd0,   8'd255, SAT ? 16'h0000 : 16'hFF01, 1'b1, 8'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Table-driven back-to-back beats through the scoreboard
        sb_en = 1'b1;
        foreach (vecs[i]) send(vecs[i]);

        // Counter saturation: 260 ACC beats after a LOAD
        send('{M_LOAD, 8'd0, 8'd0, 16'd0, 1'b0, 8'd1});
        for (int i = 0; i < 260; i++) begin
            send('{M_ACC, 8'd0, 8'd0, 16'd0, 1'b0,
                   (i + 2 > 255) ? 8'd255 : 8'(i + 2)});
        end
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("drained_out_valid", 32'(out_valid), 32'd0);
        sb_en = 1'b0;

        // Narrow accumulator (ACC_WIDTH=9) overflow
        narrow_step(M_LOAD, 8'd255, 8'd255, 9'd510, 1'b0, 8'd1, "n_load");
        narrow_step(M_ACC,  8'd1,   8'd0,   9'd511, 1'b0, 8'd2, "n_acc1");
        narrow_step(M_ACC,  8'd1,   8'd0,   SAT ? 9'd511 : 9'd0, 1'b1, 8'd3, "n_acc2");

        // Backpressure: result holds and input stalls while out_ready=0
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = M_ADD;
        in_a      = 8'd1;
        in_b      = 8'd2;
        @(posedge clk);
        #1;
        in_mode = M_LOAD;
        in_a    = 8'd9;
        in_b    = 8'd9;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'd3);
            check("bp_out_count", 32'(out_count), 32'd255);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data",  32'(out_data),  32'd18);
        check("bp_next_count", 32'(out_count), 32'd1);
        @(posedge clk);
        #1;
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Reset while a result is held mid-accumulation
        in_valid = 1'b1;
        in_mode  = M_LOAD;
        in_a     = 8'd1;
        in_b     = 8'd1;
        @(posedge clk);
        #1;
        in_mode = M_ACC;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_data",  32'(out_data),  32'd4);
        check("pre_rst_count", 32'(out_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = M_ACC;
        in_a      = 8'd3;
        in_b      = 8'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  32'(out_data),  32'd7);
        check("post_rst_carry", 32'(out_carry), 32'd0);
        check("post_rst_count", 32'(out_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
